// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin grant controller.
package arb_pkg;

  localparam int unsigned DEFAULT_N         = 8;
  localparam int unsigned DEFAULT_MAX_BEATS = 16;

  // Two-state controller encoding kept as plain constants for legacy tools.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

endpackage : arb_pkg

// File: rtl/rr_grant_ctrl_if.sv
// Requester-bank / shared-resource signal bundle for rr_grant_ctrl.
interface rr_grant_ctrl_if
  import arb_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
);

  localparam int unsigned IDXW = $clog2(N);
  localparam int unsigned CNTW = $clog2(N + 1);

  logic [N-1:0]    reqs_i;
  logic            ready_i;
  logic            last_i;
  logic            grant_vld_o;
  logic [IDXW-1:0] grant_idx_o;
  logic [N-1:0]    grant_oh_o;
  logic [IDXW-1:0] lowp_o;
  logic [CNTW-1:0] cnt_o;
  logic            busy_o;

  // Controller side.
  modport slave (
    input  reqs_i,
    input  ready_i,
    input  last_i,
    output grant_vld_o,
    output grant_idx_o,
    output grant_oh_o,
    output lowp_o,
    output cnt_o,
    output busy_o
  );

  // Requester bank / resource side.
  modport master (
    output reqs_i,
    output ready_i,
    output last_i,
    input  grant_vld_o,
    input  grant_idx_o,
    input  grant_oh_o,
    input  lowp_o,
    input  cnt_o,
    input  busy_o
  );

endinterface : rr_grant_ctrl_if

// File: rtl/rr_pick.sv
// Rotating first-set-bit search: lowest offset from ptr (mod N) wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N    = DEFAULT_N,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    reqs,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  // Scan offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    int unsigned pos;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = 32'(ptr) + 32'(k);
      if (pos >= N) begin
        pos = pos - N;
      end
      if (reqs[pos[IDXW-1:0]]) begin
        idx   = pos[IDXW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_grant_ctrl.sv
// Fair round-robin owner of a shared multi-beat resource among N requesters.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned N         = DEFAULT_N,
  parameter int unsigned MAX_BEATS = DEFAULT_MAX_BEATS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rr_grant_ctrl_if.slave  bus
);

  localparam int unsigned IDXW = $clog2(N);
  localparam int unsigned CNTW = $clog2(N + 1);
  localparam int unsigned BW   = $clog2(MAX_BEATS + 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] lowp_q, lowp_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic            gvld_q, gvld_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [N-1:0]    goh_q, goh_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic [IDXW-1:0] pick_idx;
  logic            pick_found;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .reqs  (bus.reqs_i),
    .ptr   (lowp_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state: arbitration in IDLE, beat tracking and release in GRANT.
  always_comb begin
    logic            release_c;
    logic            win_req_c;
    logic [BW-1:0]   beats_inc_c;

    state_d     = state_q;
    lowp_d      = lowp_q;
    beats_d     = beats_q;
    gvld_d      = gvld_q;
    gidx_d      = gidx_q;
    goh_d       = goh_q;
    cnt_d       = '0;
    busy_d      = busy_q;
    release_c   = 1'b0;
    win_req_c   = bus.reqs_i[gidx_q];
    beats_inc_c = beats_q + BW'(1);

    // Population count of the live request vector, every cycle.
    for (int i = 0; i < int'(N); i++) begin
      cnt_d = cnt_d + CNTW'(bus.reqs_i[i]);
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gidx_d           = pick_idx;
          goh_d            = '0;
          goh_d[pick_idx]  = 1'b1;
          gvld_d           = 1'b1;
          state_d          = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Abort outranks any beat presented on the same cycle.
        if (!win_req_c) begin
          release_c = 1'b1;
        end else if (gvld_q && bus.ready_i) begin
          beats_d = beats_inc_c;
          if (bus.last_i || (beats_inc_c == BW'(MAX_BEATS))) begin
            release_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Release: rotate pointer past the winner; grant_idx keeps its value.
    if (release_c) begin
      lowp_d  = (gidx_q == IDXW'(N - 1)) ? '0 : gidx_q + IDXW'(1);
      beats_d = '0;
      gvld_d  = 1'b0;
      goh_d   = '0;
      state_d = ST_IDLE;
    end

    busy_d = (state_d == ST_GRANT);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      lowp_q  <= '0;
      beats_q <= '0;
      gvld_q  <= 1'b0;
      gidx_q  <= '0;
      goh_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lowp_q  <= lowp_d;
      beats_q <= beats_d;
      gvld_q  <= gvld_d;
      gidx_q  <= gidx_d;
      goh_q   <= goh_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant_vld_o = gvld_q;
  assign bus.grant_idx_o = gidx_q;
  assign bus.grant_oh_o  = goh_q;
  assign bus.lowp_o      = lowp_q;
  assign bus.cnt_o       = cnt_q;
  assign bus.busy_o      = busy_q;

endmodule : rr_grant_ctrl

// File: tb/tb_rr_grant_ctrl.sv
// Directed scoreboard bench for rr_grant_ctrl (N=8, MAX_BEATS=4).
module tb_rr_grant_ctrl;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
    logic [2:0] lowp;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total  = 0;
  int    passed = 0;

  rr_grant_ctrl_if #(.N(8)) bus();

  rr_grant_ctrl #(
    .N         (8),
    .MAX_BEATS (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int vld, input int idx, input int lowp, input int cnt);
    exp_t e;
    e.vld  = 1'(vld);
    e.idx  = 3'(idx);
    e.lowp = 3'(lowp);
    e.cnt  = 4'(cnt);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t       e;
    string      tag;
    logic [7:0] oh;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    oh  = e.vld ? (8'd1 << e.idx) : 8'd0;
    chk(tag, "vld",  8'(bus.grant_vld_o), 8'(e.vld));
    chk(tag, "idx",  8'(bus.grant_idx_o), 8'(e.idx));
    chk(tag, "oh",   bus.grant_oh_o,      oh);
    chk(tag, "lowp", 8'(bus.lowp_o),      8'(e.lowp));
    chk(tag, "cnt",  8'(bus.cnt_o),       8'(e.cnt));
    chk(tag, "busy", 8'(bus.busy_o),      8'(e.vld));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, predict the registered outputs after the edge.
  task automatic step(input string tag, input logic [7:0] r, input logic rdy, input logic lst,
                      input int vld, input int idx, input int lowp, input int cnt);
    bus.reqs_i  = r;
    bus.ready_i = rdy;
    bus.last_i  = lst;
    push(tag, vld, idx, lowp, cnt);
    tick();
    check_out();
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.reqs_i  = '0;
    bus.ready_i = 1'b0;
    bus.last_i  = 1'b0;
    tick();
    tick();
    push("reset", 0, 0, 0, 0);
    check_out();
    rst_n = 1'b1;

    // Grant 2 from lowp 0, release, then 4 after the IDLE bubble.
    step("g2",        8'h14, 1'b0, 1'b0, 1, 2, 0, 2);
    step("g2_rel",    8'h14, 1'b1, 1'b1, 0, 2, 3, 2);
    step("g4",        8'h14, 1'b0, 1'b0, 1, 4, 3, 2);
    step("g4_rel",    8'h10, 1'b1, 1'b1, 0, 4, 5, 1);

    // Serve 6 to put lowp at 7, then wrap 7 -> 0 -> 1.
    step("g6",        8'h40, 1'b0, 1'b0, 1, 6, 5, 1);
    step("g6_rel",    8'h40, 1'b1, 1'b1, 0, 6, 7, 1);
    step("g7",        8'h81, 1'b0, 1'b0, 1, 7, 7, 2);
    step("g7_rel",    8'h81, 1'b1, 1'b1, 0, 7, 0, 2);
    step("g0",        8'h81, 1'b0, 1'b0, 1, 0, 0, 2);
    step("g0_rel",    8'h81, 1'b1, 1'b1, 0, 0, 1, 2);

    // Forced release after MAX_BEATS accepted beats.
    step("g3",        8'h08, 1'b0, 1'b0, 1, 3, 1, 1);
    step("g3_b1",     8'h08, 1'b1, 1'b0, 1, 3, 1, 1);
    step("g3_b2",     8'h08, 1'b1, 1'b0, 1, 3, 1, 1);
    step("g3_b3",     8'h08, 1'b1, 1'b0, 1, 3, 1, 1);
    step("g3_b4_rel", 8'h08, 1'b1, 1'b0, 0, 3, 4, 1);
    step("idle0",     8'h00, 1'b0, 1'b0, 0, 3, 4, 0);

    // Abort after 2 beats outranks ready/last; fresh grant gets full 4 beats.
    step("g5",        8'h20, 1'b0, 1'b0, 1, 5, 4, 1);
    step("g5_b1",     8'h20, 1'b1, 1'b0, 1, 5, 4, 1);
    step("g5_b2",     8'h20, 1'b1, 1'b0, 1, 5, 4, 1);
    step("g5_abort",  8'h00, 1'b1, 1'b1, 0, 5, 6, 0);
    step("g5b",       8'h20, 1'b0, 1'b0, 1, 5, 6, 1);
    step("g5b_b1",    8'h20, 1'b1, 1'b0, 1, 5, 6, 1);
    step("g5b_b2",    8'h20, 1'b1, 1'b0, 1, 5, 6, 1);
    step("g5b_b3",    8'h20, 1'b1, 1'b0, 1, 5, 6, 1);
    step("g5b_rel",   8'h20, 1'b1, 1'b0, 0, 5, 6, 1);

    // All requesting: count 8, last without ready ignored, others ignored.
    step("g6_all",    8'hFF, 1'b0, 1'b0, 1, 6, 6, 8);
    step("lst_nrdy",  8'hFF, 1'b0, 1'b1, 1, 6, 6, 8);
    step("rdy_beat",  8'hFF, 1'b1, 1'b0, 1, 6, 6, 8);
    step("lst_nrdy2", 8'hFF, 1'b0, 1'b1, 1, 6, 6, 8);
    step("g6_rel2",   8'hFF, 1'b1, 1'b1, 0, 6, 7, 8);
    step("cnt0",      8'h00, 1'b0, 1'b0, 0, 6, 7, 0);

    // Asynchronous reset mid-grant, then pointer restarts from 0.
    step("g0_pre",    8'h01, 1'b0, 1'b0, 1, 0, 7, 1);
    step("g0_hold",   8'h03, 1'b0, 1'b0, 1, 0, 7, 2);
    rst_n = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 0);
    check_out();
    bus.reqs_i = '0;
    tick();
    rst_n = 1'b1;
    step("post_rst",  8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
    step("g2_post",   8'h0C, 1'b0, 1'b0, 1, 2, 0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_rr_grant_ctrl

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
Sequential round-robin controller that shares one downstream resource between N requesters.
- Picks a winner starting from a rotating low-priority pointer.
- Registers the grant and holds it for a multi-beat transaction, using a valid/ready/last handshake with the resource.
- Advances the pointer past the winner on release.
- Sits between the requester bank and the shared resource, replacing purely combinational selection with a stateful, fair scheduler.

Parameters:
N, 8, number of requesters (2..16)
MAX_BEATS, 16, maximum accepted beats per grant before forced release (1..255)
IDXW, $clog2(N), width of requester index (derived, not overridden)
CNTW, $clog2(N+1), width of pending-request count (derived)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
reqs_i  input  N  request vector, bit i = requester i wants the resource
ready_i  input  1  resource accepts the current beat
last_i  input  1  current beat is the final beat of the transaction
grant_vld_o  output  1  a requester currently owns the resource
grant_idx_o  output  IDXW  index of the owning requester
grant_oh_o  output  N  one-hot copy of grant_idx_o; all zero when grant_vld_o=0
lowp_o  output  IDXW  current priority pointer (highest-priority index next arbitration)
cnt_o  output  CNTW  registered count of asserted bits in reqs_i
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, lowp=0, beat count=0.
  - All outputs 0.
  - Takes effect immediately, including mid-transaction; no beat completes on the reset cycle.
- FSM states: IDLE, GRANT.
- IDLE:
  - If reqs_i!=0, the winner is the first set bit at or after lowp, scanning upward modulo N.
  - Register grant_idx_o, grant_oh_o, grant_vld_o=1; go to GRANT.
  - Latency: request sampled at edge t, grant visible after edge t, one-cycle arbitration.
  - If reqs_i==0, stay in IDLE, outputs unchanged except cnt_o.
- GRANT:
  - A beat is accepted when grant_vld_o=1 and ready_i=1; beat count increments.
  - Release occurs on the first of these, checked in priority order:
    - (a) winner's reqs_i bit is 0 (abort). No beat is counted even if ready_i=1.
    - (b) accepted beat with last_i=1 (normal completion).
    - (c) accepted beat that makes beat count == MAX_BEATS (forced release).
  - On release, at the same edge:
    - lowp <= (winner+1) mod N;
    - beat count <= 0;
    - grant_vld_o <= 0, grant_oh_o <= 0;
    - state <= IDLE.
    - grant_idx_o keeps its last value.
- One-cycle bubble in IDLE between consecutive grants is required. No back-to-back grant without passing through IDLE.
- Requests from non-winners during GRANT are ignored. They are not latched, and must be held to be served.
- last_i with ready_i=0 has no effect.
- Wrap-around: winner N-1 -> lowp=0. Scan from lowp=N-1 continues at index 0.
- cnt_o: population count of reqs_i, registered every cycle in all states. Width CNTW, so all-ones gives N with no overflow.
- busy_o = (state==GRANT).

Decomposition:
- Package arb_pkg: state enum (IDLE, GRANT), default N and MAX_BEATS constants.
- Sub-module rr_pick (purely combinational):
  - inputs: reqs, ptr.
  - outputs: idx, found.
  - Rotating first-set-bit search; instanced once.
- Beat counter width: $clog2(MAX_BEATS+1).

Test Plan:
1. Assert rst_ni=0 mid-GRANT with no clock edge -> all outputs 0 and lowp_o=0 immediately; after release, reqs_i=0 keeps busy_o=0.
2. lowp=0, reqs_i=8'b0001_0100 -> grant_idx_o=2 one cycle later.
   - ready_i=1 with last_i=1 -> release; lowp_o=3.
   - Next grant after IDLE bubble -> grant_idx_o=4; lowp_o=5 after its release.
3. Drive lowp to 7 by serving requester 6, then reqs_i=8'b1000_0001 -> grant 7, lowp_o=0; then grant 0, lowp_o=1.
4. MAX_BEATS=4, requester 3 holds req, ready_i=1, last_i=0 -> exactly 4 beats accepted, grant_vld_o=0 next cycle, lowp_o=4.
5. Requester 5 granted, drops req after 2 beats with ready_i=1 -> release that edge, no third beat counted, lowp_o=6.
6. reqs_i=8'hFF -> cnt_o=8 one cycle later; reqs_i=8'h00 -> cnt_o=0; ready_i toggling with last_i=1 while ready_i=0 -> no release.
